// File: rtl/regfile_mp_pkg.sv
// Shared CPU register-file definitions: default geometry, the hardwired-zero
// address and the write-port priority encoding also used by the hazard unit.
package regfile_mp_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    localparam int REG_ZERO   = 0;

    typedef enum logic [0:0] {
        PORT_A_PRIO = 1'b0,
        PORT_B_PRIO = 1'b1
    } wr_prio_e;

    localparam wr_prio_e WR_PRIO = PORT_A_PRIO;

    // A request to register 0 is swallowed when that register is hardwired.
    function automatic logic wr_allowed(input logic en, input logic is_zero, input logic zero_reg);
        return en && !(zero_reg && is_zero);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on reservation, cleared by late (port B)
// writeback, looked up for the two effective read addresses.
module rf_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_busy,
    input  logic [ADDR_W-1:0] busy_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              busy1,
    output logic              busy2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_clr;
    logic             w_set_ok;
    logic             w_fwd1;
    logic             w_fwd2;

    assign w_set_ok = wr_allowed(set_busy, busy_addr == ADDR_W'(REG_ZERO), ZERO_REG != 0);

    // Decode set and clear requests into one-hot vectors.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_set_ok) begin
            w_set[busy_addr] = 1'b1;
        end else begin
            w_set = '0;
        end
        if (clr_en) begin
            w_clr[clr_addr] = 1'b1;
        end else begin
            w_clr = '0;
        end
    end

    // Busy vector; a new reservation beats a retiring writeback to the same register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_set[i]) begin
                    r_busy[i] <= 1'b1;
                end else if (w_clr[i]) begin
                    r_busy[i] <= 1'b0;
                end else begin
                    r_busy[i] <= r_busy[i];
                end
            end
        end
    end

    assign w_fwd1 = (BYPASS != 0) && clr_en && (clr_addr == rd_addr1);
    assign w_fwd2 = (BYPASS != 0) && clr_en && (clr_addr == rd_addr2);
    assign busy1  = r_busy[rd_addr1] && !w_fwd1;
    assign busy2  = r_busy[rd_addr2] && !w_fwd2;

endmodule

// File: rtl/regfile_mp.sv
// Two-write, two-read register file with optional bypass, hardwired zero
// register and a busy scoreboard for pending late writebacks.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              we4,
    input  logic [ADDR_W-1:0] wa4,
    input  logic [DATA_W-1:0] wd4,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic              storeg,
    input  logic              set_busy,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    output logic              collide
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_collide;
    logic              w_zero_en;
    logic              w_we3_ok;
    logic              w_we4_ok;
    logic              w_same;
    logic              w_we3_eff;
    logic              w_we4_eff;
    logic              w_byp_en;
    logic [ADDR_W-1:0] w_ra2;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    assign w_zero_en = (ZERO_REG != 0);
    assign w_we3_ok  = wr_allowed(we3, wa3 == ADDR_W'(REG_ZERO), w_zero_en);
    assign w_we4_ok  = wr_allowed(we4, wa4 == ADDR_W'(REG_ZERO), w_zero_en);
    assign w_same    = w_we3_ok && w_we4_ok && (wa3 == wa4);
    assign w_we3_eff = w_we3_ok && !(w_same && (WR_PRIO == PORT_B_PRIO));
    assign w_we4_eff = w_we4_ok && !(w_same && (WR_PRIO == PORT_A_PRIO));
    assign w_byp_en  = (BYPASS != 0) && !reset;
    assign w_ra2     = storeg ? wa3 : ra2;

    // Array update and collision flag; the losing port of a same-address pair is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_collide <= 1'b0;
        end else begin
            if (w_we4_eff) begin
                r_mem[wa4] <= wd4;
            end
            if (w_we3_eff) begin
                r_mem[wa3] <= wd3;
            end
            r_collide <= w_same;
        end
    end

    // Read port 1 with port-A-first forwarding.
    always_comb begin
        w_rd1 = r_mem[ra1];
        if (w_zero_en && (ra1 == ADDR_W'(REG_ZERO))) begin
            w_rd1 = '0;
        end else if (w_byp_en && w_we3_ok && (wa3 == ra1)) begin
            w_rd1 = wd3;
        end else if (w_byp_en && w_we4_ok && (wa4 == ra1)) begin
            w_rd1 = wd4;
        end else begin
            w_rd1 = r_mem[ra1];
        end
    end

    // Read port 2 (store-source aware) with port-A-first forwarding.
    always_comb begin
        w_rd2 = r_mem[w_ra2];
        if (w_zero_en && (w_ra2 == ADDR_W'(REG_ZERO))) begin
            w_rd2 = '0;
        end else if (w_byp_en && w_we3_ok && (wa3 == w_ra2)) begin
            w_rd2 = wd3;
        end else if (w_byp_en && w_we4_ok && (wa4 == w_ra2)) begin
            w_rd2 = wd4;
        end else begin
            w_rd2 = r_mem[w_ra2];
        end
    end

    rf_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_busy (set_busy),
        .busy_addr(busy_addr),
        .clr_en   (w_we4_ok),
        .clr_addr (wa4),
        .rd_addr1 (ra1),
        .rd_addr2 (w_ra2),
        .busy1    (busy1),
        .busy2    (busy2)
    );

    assign rd1     = w_rd1;
    assign rd2     = w_rd2;
    assign collide = r_collide;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: u_a is the bypassing build, u_n has no bypass and a
// hardwired r0; both share one stimulus stream.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset, we3, we4, storeg, set_busy;
    logic [2:0]  wa3, wa4, ra1, ra2, busy_addr;
    logic [15:0] wd3, wd4;
    logic [15:0] a_rd1, a_rd2, n_rd1, n_rd2;
    logic        a_b1, a_b2, a_col, n_b1, n_b2, n_col;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // mask bits [4:0] = u_a {col,b2,b1,rd2,rd1}, [9:5] = u_n likewise
    typedef struct {
        string       name;
        logic [9:0]  m;
        logic [15:0] rd1, rd2;
        logic        b1, b2, col;
        logic [15:0] nrd1, nrd2;
        logic        nb1, nb2, ncol;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_a (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4), .ra1(ra1), .ra2(ra2),
        .storeg(storeg), .set_busy(set_busy), .busy_addr(busy_addr),
        .rd1(a_rd1), .rd2(a_rd2), .busy1(a_b1), .busy2(a_b2), .collide(a_col)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_n (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4), .ra1(ra1), .ra2(ra2),
        .storeg(storeg), .set_busy(set_busy), .busy_addr(busy_addr),
        .rd1(n_rd1), .rd2(n_rd2), .busy1(n_b1), .busy2(n_b2), .collide(n_col)
    );

    task automatic chk(input string nm, input string f, input logic [15:0] act, input logic [15:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s.%s got %h expected %h", nm, f, act, want);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, so pop one expectation per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.m[0]) chk(e.name, "a_rd1", a_rd1, e.rd1);
                if (e.m[1]) chk(e.name, "a_rd2", a_rd2, e.rd2);
                if (e.m[2]) chk(e.name, "a_busy1", {15'd0, a_b1}, {15'd0, e.b1});
                if (e.m[3]) chk(e.name, "a_busy2", {15'd0, a_b2}, {15'd0, e.b2});
                if (e.m[4]) chk(e.name, "a_collide", {15'd0, a_col}, {15'd0, e.col});
                if (e.m[5]) chk(e.name, "n_rd1", n_rd1, e.nrd1);
                if (e.m[6]) chk(e.name, "n_rd2", n_rd2, e.nrd2);
                if (e.m[7]) chk(e.name, "n_busy1", {15'd0, n_b1}, {15'd0, e.nb1});
                if (e.m[8]) chk(e.name, "n_busy2", {15'd0, n_b2}, {15'd0, e.nb2});
                if (e.m[9]) chk(e.name, "n_collide", {15'd0, n_col}, {15'd0, e.ncol});
            end
        end
    end

    task automatic drv(input logic rst, input logic e3, input logic [2:0] a3, input logic [15:0] d3,
                       input logic e4, input logic [2:0] a4, input logic [15:0] d4,
                       input logic [2:0] r1, input logic [2:0] r2, input logic stg,
                       input logic sb, input logic [2:0] ba);
        reset = rst; we3 = e3; wa3 = a3; wd3 = d3; we4 = e4; wa4 = a4; wd4 = d4;
        ra1 = r1; ra2 = r2; storeg = stg; set_busy = sb; busy_addr = ba;
    endtask

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic cyc(input string nm, input logic [9:0] m,
                       input logic [15:0] rd1_e, input logic [15:0] rd2_e,
                       input logic b1_e, input logic b2_e, input logic col_e,
                       input logic [15:0] nrd1_e, input logic [15:0] nrd2_e,
                       input logic nb1_e, input logic nb2_e, input logic ncol_e);
        exp_t e;
        e.name = nm; e.m = m;
        e.rd1 = rd1_e; e.rd2 = rd2_e; e.b1 = b1_e; e.b2 = b2_e; e.col = col_e;
        e.nrd1 = nrd1_e; e.nrd2 = nrd2_e; e.nb1 = nb1_e; e.nb2 = nb2_e; e.ncol = ncol_e;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        drv(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
        @(posedge clk);
        #1;
        // reset
        cyc("rst0", {5'b00000, 5'b00000}, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0, 3'd3, 3'd0, 1'b0, 1'b0, 3'd0);
        cyc("wr_r3", {5'b00001, 5'b10001}, 16'h1234, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd0, 1'b0, 1'b0, 3'd0);
        cyc("rst1", {5'b00000, 5'b00000}, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd0, 1'b0, 1'b0, 3'd0);
        cyc("post_rst", {5'b10101, 5'b10101}, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        // bypass
        drv(1'b0, 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 16'h0, 3'd5, 3'd0, 1'b0, 1'b0, 3'd0);
        cyc("byp_same", {5'b00001, 5'b00001}, 16'hBEEF, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 3'd5, 3'd0, 1'b0, 1'b0, 3'd0);
        cyc("byp_next", {5'b00001, 5'b00001}, 16'hBEEF, 16'h0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h0, 1'b0, 1'b0, 1'b0);
        // dual-write collision
        drv(1'b0, 1'b1, 3'd2, 16'h0011, 1'b1, 3'd2, 16'h0022, 3'd2, 3'd0, 1'b0, 1'b0, 3'd0);
        cyc("coll_wr", {5'b00001, 5'b10001}, 16'h0011, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd0, 1'b0, 1'b0, 3'd0);
        cyc("coll_1", {5'b10001, 5'b10001}, 16'h0011, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0011, 16'h0, 1'b0, 1'b0, 1'b1);
        cyc("coll_2", {5'b10000, 5'b10000}, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        // scoreboard
        drv(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd4, 1'b0, 1'b1, 3'd4);
        cyc("sb_set", {5'b01000, 5'b01000}, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd4, 1'b0, 1'b0, 3'd0);
        cyc("sb_vis", {5'b01000, 5'b01000}, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        drv(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h00AA, 3'd0, 3'd4, 1'b0, 1'b0, 3'd0);
        cyc("sb_clr", {5'b01010, 5'b01010}, 16'h0, 16'h00AA, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        drv(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd4, 1'b0, 1'b0, 3'd0);
        cyc("sb_after", {5'b01010, 5'b01010}, 16'h0, 16'h00AA, 1'b0, 1'b0, 1'b0, 16'h0, 16'h00AA, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h00BB, 3'd0, 3'd4, 1'b0, 1'b1, 3'd4);
        cyc("sb_setclr", {5'b01010, 5'b01010}, 16'h0, 16'h00BB, 1'b0, 1'b0, 1'b0, 16'h0, 16'h00AA, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd4, 1'b0, 1'b0, 3'd0);
        cyc("sb_setwin", {5'b01010, 5'b01010}, 16'h0, 16'h00BB, 1'b0, 1'b1, 1'b0, 16'h0, 16'h00BB, 1'b0, 1'b1, 1'b0);
        drv(1'b0, 1'b1, 3'd4, 16'h00CC, 1'b0, 3'd0, 16'h0, 3'd4, 3'd0, 1'b0, 1'b0, 3'd0);
        cyc("sb_awr", {5'b00101, 5'b00101}, 16'h00CC, 16'h0, 1'b1, 1'b0, 1'b0, 16'h00BB, 16'h0, 1'b1, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 3'd4, 3'd0, 1'b0, 1'b0, 3'd0);
        cyc("sb_astill", {5'b00101, 5'b00101}, 16'h00CC, 16'h0, 1'b1, 1'b0, 1'b0, 16'h00CC, 16'h0, 1'b1, 1'b0, 1'b0);
        // store mode
        drv(1'b0, 1'b1, 3'd6, 16'h7777, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
        cyc("st_w6", 10'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b1, 3'd1, 16'h1111, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
        cyc("st_w1", 10'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 3'd6, 16'h0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd1, 1'b0, 1'b0, 3'd0);
        cyc("st_off", {5'b00010, 5'b00010}, 16'h0, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0, 16'h1111, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 3'd6, 16'h0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd1, 1'b1, 1'b0, 3'd0);
        cyc("st_on", {5'b00010, 5'b00010}, 16'h0, 16'h7777, 1'b0, 1'b0, 1'b0, 16'h0, 16'h7777, 1'b0, 1'b0, 1'b0);
        // zero register (u_n hardwired, u_a ordinary)
        drv(1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd0);
        cyc("z_wr", {5'b10101, 5'b00101}, 16'hFFFF, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
        cyc("z_next", {5'b10101, 5'b10101}, 16'hFFFF, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b1, 3'd0, 16'h0001, 1'b1, 3'd0, 16'h0002, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
        cyc("z_dual", {5'b00001, 5'b00101}, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
        cyc("z_coll", {5'b10000, 5'b10101}, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
